// File: rtl/rrv64_clkgate_pkg.sv
// Shared types and default sizing for the L1D clock-gating controller.
package rrv64_clkgate_pkg;

  localparam int CG_N_CH_DEF     = 4;
  localparam int CG_CNT_W_DEF    = 8;
  localparam int CG_WAKE_LAT_DEF = 2;

  // Per-channel gating FSM states.
  typedef enum logic [1:0] {
    CG_RUN   = 2'd0,
    CG_IDLE  = 2'd1,
    CG_GATED = 2'd2,
    CG_WAKE  = 2'd3
  } cg_state_e;

endpackage

// File: rtl/rrv64_cell_icg.sv
// Behavioural integrated clock gate: low-transparent latch followed by AND.
// Port-compatible with a library ICG cell, which may be substituted directly.
module rrv64_cell_icg (
  input  logic clk_i,
  input  logic en_i,
  input  logic te_i,
  output logic clk_o
);

  logic r_en_lat;

  // Latch the combined enable while the clock is low so clk_o cannot glitch.
  always_latch begin
    if (!clk_i) begin
      r_en_lat <= en_i | te_i;
    end
  end

  assign clk_o = clk_i & r_en_lat;

endmodule

// File: rtl/rrv64_clkgate_ctrl.sv
// Multi-channel clock-gating controller: per-channel idle hysteresis,
// gate/wake FSM and one ICG per channel. Scan enable forces clocks on
// without touching FSM state.
module rrv64_clkgate_ctrl
  import rrv64_clkgate_pkg::*;
#(
  parameter int N_CH     = CG_N_CH_DEF,
  parameter int CNT_W    = CG_CNT_W_DEF,
  parameter int WAKE_LAT = CG_WAKE_LAT_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             test_en_i,
  input  logic [CNT_W-1:0] idle_thresh_i,
  input  logic [N_CH-1:0]  busy_i,
  input  logic [N_CH-1:0]  wake_req_i,
  input  logic [N_CH-1:0]  force_on_i,
  output logic [N_CH-1:0]  wake_ack_o,
  output logic [N_CH-1:0]  gated_o,
  output logic [N_CH-1:0]  clk_gated_o
);

  // Wake counter only needs to reach WAKE_LAT-1; keep at least one bit.
  localparam int              WCNT_W    = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
  localparam int              WLAST_I   = (WAKE_LAT > 0) ? (WAKE_LAT - 1) : 0;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WLAST_I);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [CNT_W:0]    CNT_ONE   = (CNT_W + 1)'(1);
  localparam logic              WAKE_BYPASS = (WAKE_LAT == 0);

  // Threshold of zero disables gating for every channel.
  logic w_thr_zero;
  assign w_thr_zero = (idle_thresh_i == {CNT_W{1'b0}});

  for (genvar c = 0; c < N_CH; c++) begin : g_ch

    cg_state_e         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [WCNT_W-1:0] r_wcnt;
    logic              r_en;
    logic              r_ack;
    logic              r_gated;

    logic              w_hold;
    logic [CNT_W:0]    w_cnt_inc;
    logic              w_cnt_hit;

    // Any activity, explicit request or software override keeps the clock.
    assign w_hold = busy_i[c] | wake_req_i[c] | force_on_i[c];

    // One extra bit so the increment never wraps before the compare.
    assign w_cnt_inc = {1'b0, r_cnt} + CNT_ONE;
    assign w_cnt_hit = (w_cnt_inc >= {1'b0, idle_thresh_i});

    // Channel FSM with registered gate enable and status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_state <= CG_RUN;
        r_cnt   <= {CNT_W{1'b0}};
        r_wcnt  <= {WCNT_W{1'b0}};
        r_en    <= 1'b1;
        r_ack   <= 1'b1;
        r_gated <= 1'b0;
      end else begin
        case (r_state)
          CG_RUN, CG_IDLE: begin
            if (w_hold || w_thr_zero) begin
              r_state <= CG_RUN;
              r_cnt   <= {CNT_W{1'b0}};
              r_en    <= 1'b1;
              r_ack   <= 1'b1;
              r_gated <= 1'b0;
            end else if (w_cnt_hit) begin
              // Compare is >= so a threshold lowered mid-count still gates.
              r_state <= CG_GATED;
              r_cnt   <= {CNT_W{1'b0}};
              r_en    <= 1'b0;
              r_ack   <= 1'b0;
              r_gated <= 1'b1;
            end else begin
              r_state <= CG_IDLE;
              r_cnt   <= w_cnt_inc[CNT_W-1:0];
              r_en    <= 1'b1;
              r_ack   <= 1'b1;
              r_gated <= 1'b0;
            end
          end
          CG_GATED: begin
            if (w_hold) begin
              r_en    <= 1'b1;
              r_gated <= 1'b0;
              r_wcnt  <= {WCNT_W{1'b0}};
              r_cnt   <= {CNT_W{1'b0}};
              if (WAKE_BYPASS) begin
                r_state <= CG_RUN;
                r_ack   <= 1'b1;
              end else begin
                r_state <= CG_WAKE;
                r_ack   <= 1'b0;
              end
            end else begin
              r_state <= CG_GATED;
              r_en    <= 1'b0;
              r_ack   <= 1'b0;
              r_gated <= 1'b1;
            end
          end
          CG_WAKE: begin
            // Not abortable: the clock settles to RUN whatever hold does.
            r_en    <= 1'b1;
            r_gated <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
            if (r_wcnt == WCNT_LAST) begin
              r_state <= CG_RUN;
              r_wcnt  <= {WCNT_W{1'b0}};
              r_ack   <= 1'b1;
            end else begin
              r_state <= CG_WAKE;
              r_wcnt  <= r_wcnt + WCNT_ONE;
              r_ack   <= 1'b0;
            end
          end
          default: begin
            r_state <= CG_RUN;
            r_cnt   <= {CNT_W{1'b0}};
            r_wcnt  <= {WCNT_W{1'b0}};
            r_en    <= 1'b1;
            r_ack   <= 1'b1;
            r_gated <= 1'b0;
          end
        endcase
      end
    end

    assign wake_ack_o[c] = r_ack;
    assign gated_o[c]    = r_gated;

    rrv64_cell_icg u_icg (
      .clk_i (clk_i),
      .en_i  (r_en),
      .te_i  (test_en_i),
      .clk_o (clk_gated_o[c])
    );

  end : g_ch

endmodule

// File: tb/tb_rrv64_clkgate_ctrl.sv
// Directed bench for rrv64_clkgate_ctrl with a per-cycle behavioural model.
module tb_rrv64_clkgate_ctrl;

  localparam int N_CH = 4;
  localparam int CNT_W = 8;
  localparam int WL = 2;

  localparam int M_ON = 0;
  localparam int M_GATED = 1;
  localparam int M_WAKING = 2;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             test_en_i;
  logic [CNT_W-1:0] idle_thresh_i;
  logic [N_CH-1:0]  busy_i;
  logic [N_CH-1:0]  wake_req_i;
  logic [N_CH-1:0]  force_on_i;
  logic [N_CH-1:0]  wake_ack_o;
  logic [N_CH-1:0]  gated_o;
  logic [N_CH-1:0]  clk_gated_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  // Model: a channel is either running (counting idle cycles), gated, or waking.
  int m_mode [N_CH];
  int m_idle [N_CH];
  int m_wleft[N_CH];

  rrv64_clkgate_ctrl #(.N_CH(N_CH), .CNT_W(CNT_W), .WAKE_LAT(WL)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .test_en_i    (test_en_i),
    .idle_thresh_i(idle_thresh_i),
    .busy_i       (busy_i),
    .wake_req_i   (wake_req_i),
    .force_on_i   (force_on_i),
    .wake_ack_o   (wake_ack_o),
    .gated_o      (gated_o),
    .clk_gated_o  (clk_gated_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [N_CH-1:0] act, input logic [N_CH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Per-edge model update and comparison of all outputs, sampled 1 time unit after the edge.
  initial begin
    logic [N_CH-1:0] exp_clk, exp_ack, exp_gated;
    bit hold;
    for (int c = 0; c < N_CH; c++) begin
      m_mode[c] = M_ON; m_idle[c] = 0; m_wleft[c] = 0;
    end
    forever begin
      @(posedge clk_i);
      for (int c = 0; c < N_CH; c++) begin
        if (!rst_ni) begin
          m_mode[c] = M_ON; m_idle[c] = 0; m_wleft[c] = 0;
        end
        // A pulse appears when the clock was enabled going into this edge.
        exp_clk[c] = (m_mode[c] != M_GATED) || test_en_i;
        if (rst_ni) begin
          hold = busy_i[c] | wake_req_i[c] | force_on_i[c];
          if (m_mode[c] == M_ON) begin
            if (hold || idle_thresh_i == 0) begin
              m_idle[c] = 0;
            end else begin
              m_idle[c] = m_idle[c] + 1;
              if (m_idle[c] >= int'(idle_thresh_i)) begin
                m_mode[c] = M_GATED; m_idle[c] = 0;
              end
            end
          end else if (m_mode[c] == M_GATED) begin
            if (hold) begin
              if (WL == 0) m_mode[c] = M_ON;
              else begin m_mode[c] = M_WAKING; m_wleft[c] = WL; end
            end
          end else begin
            m_wleft[c] = m_wleft[c] - 1;
            if (m_wleft[c] == 0) begin m_mode[c] = M_ON; m_idle[c] = 0; end
          end
        end
        exp_ack[c]   = (m_mode[c] == M_ON);
        exp_gated[c] = (m_mode[c] == M_GATED);
      end
      #1;
      if (chk_on) begin
        check("clk_pulse", clk_gated_o, exp_clk);
        check("model_wake_ack", wake_ack_o, exp_ack);
        check("model_gated", gated_o, exp_gated);
      end
    end
  end

  // Directed stimulus with hand-computed expectations at key points.
  initial begin
    rst_ni = 1'b0; test_en_i = 1'b0; idle_thresh_i = 8'd3;
    busy_i = 4'b0000; wake_req_i = 4'b0000; force_on_i = 4'b0000;
    step(1);
    chk_on = 1'b1;
    step(1);
    check("reset_ack", wake_ack_o, 4'b1111);
    check("reset_gated", gated_o, 4'b0000);

    // Gate after threshold 3.
    rst_ni = 1'b1;
    step(2);
    check("thr3_not_yet", gated_o, 4'b0000);
    step(1);
    check("thr3_gated", gated_o, 4'b1111);
    check("thr3_ack_low", wake_ack_o, 4'b0000);

    // Wake handshake on channel 1.
    wake_req_i = 4'b0010;
    step(1);
    wake_req_i = 4'b0000;
    check("wake_gated_fall", gated_o, 4'b1101);
    check("wake_ack_w0", wake_ack_o, 4'b0000);
    step(1);
    check("wake_ack_w1", wake_ack_o, 4'b0000);
    step(1);
    check("wake_ack_w2", wake_ack_o, 4'b0010);
    step(3);
    check("regate_ch1", gated_o, 4'b1111);

    // Idle interrupted on channel 0, threshold 4.
    busy_i = 4'b1111;
    step(3);
    check("wake_all", wake_ack_o, 4'b1111);
    idle_thresh_i = 8'd4; busy_i = 4'b0000;
    step(2);
    busy_i = 4'b0001;
    step(1);
    busy_i = 4'b0000;
    step(1);
    check("intr_others_gated", gated_o, 4'b1110);
    step(2);
    check("intr_ch0_counting", gated_o, 4'b1110);
    step(1);
    check("intr_ch0_gated", gated_o, 4'b1111);

    // Threshold corners.
    busy_i = 4'b1111;
    step(3);
    idle_thresh_i = 8'd0; busy_i = 4'b0000;
    step(20);
    check("thr0_never", gated_o, 4'b0000);
    idle_thresh_i = 8'd1;
    step(1);
    check("thr1_gated", gated_o, 4'b1111);
    busy_i = 4'b1111;
    step(3);
    busy_i = 4'b0000; idle_thresh_i = 8'd10;
    step(5);
    check("thr10_cnt5", gated_o, 4'b0000);
    idle_thresh_i = 8'd2;
    step(1);
    check("thr_lowered", gated_o, 4'b1111);

    // Test enable while gated, then force-on for channel 2.
    test_en_i = 1'b1;
    step(3);
    check("te_gated_held", gated_o, 4'b1111);
    test_en_i = 1'b0;
    force_on_i = 4'b0100; busy_i = 4'b1111;
    step(3);
    busy_i = 4'b0000; idle_thresh_i = 8'd3;
    step(10);
    check("force_ch2", gated_o, 4'b1011);
    force_on_i = 4'b0000;
    step(3);
    check("force_released", gated_o, 4'b1111);

    // Reset in the middle of WAKE.
    wake_req_i = 4'b1111;
    step(1);
    wake_req_i = 4'b0000;
    check("in_wake_ack", wake_ack_o, 4'b0000);
    rst_ni = 1'b0;
    #1;
    check("rst_wake_ack", wake_ack_o, 4'b1111);
    check("rst_wake_gated", gated_o, 4'b0000);
    step(2);
    rst_ni = 1'b1;
    step(3);
    check("post_rst_regate", gated_o, 4'b1111);

    step(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
